// File: rtl/fft_bfp_scale.sv
// fft_bfp_scale: converts block-floating-point FFT beats to fixed point with a per-frame
// shift taken from the sop beat, checks framing, and drives a skid-buffered output stage.
module fft_bfp_scale #(
  parameter int FRAME_LEN = 1024,
  parameter int SHIFT_ADJ = -10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sink_valid,
  output logic        sink_ready,
  input  logic [1:0]  sink_error,
  input  logic        sink_sop,
  input  logic        sink_eop,
  input  logic [31:0] sink_real,
  input  logic [31:0] sink_imag,
  input  logic [5:0]  sink_exp,
  output logic        source_valid,
  input  logic        source_ready,
  output logic [1:0]  source_error,
  output logic        source_sop,
  output logic        source_eop,
  output logic [31:0] source_real,
  output logic [31:0] source_imag,
  output logic        frame_err,
  output logic        sat_flag
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
    logic [1:0]  err;
    logic        sop;
    logic        eop;
  } beat_t;

  function automatic logic signed [5:0] calc_shift(input logic [5:0] e);
    int t;
    t = SHIFT_ADJ - int'($signed(e));
    t = (t > 31) ? 31 : ((t < -31) ? -31 : t);
    return 6'(t);
  endfunction

  // Returns {saturated, result}; right shifts floor, left shifts clip by sign.
  function automatic logic [32:0] scale_fn(input logic signed [31:0] x, input logic signed [5:0] s);
    logic signed [63:0] wide;
    logic [5:0]         amt;
    logic [32:0]        r;
    wide = {{32{x[31]}}, x};
    amt  = 6'd0;
    if (s > 6'sd0) begin
      amt  = 6'(s);
      wide = wide <<< amt;
      if (wide > 64'sh0000_0000_7FFF_FFFF) begin
        r = {1'b1, 32'h7FFF_FFFF};
      end else if (wide < 64'shFFFF_FFFF_8000_0000) begin
        r = {1'b1, 32'h8000_0000};
      end else begin
        r = {1'b0, wide[31:0]};
      end
    end else if (s < 6'sd0) begin
      amt = 6'(-s);
      r   = {1'b0, 32'(x >>> amt)};
    end else begin
      r = {1'b0, x};
    end
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic signed [5:0]  s_q, s_d, s_new, s_use;
  logic               ready_q, ready_d;
  logic               out_valid_q, out_valid_d;
  logic               skid_full_q, skid_full_d;
  logic               frame_err_q, frame_err_d;
  logic               sat_q, sat_d;
  beat_t              out_q, out_d, skid_q, skid_d, beat;
  logic               beat_v, acc, out_fire, last;
  logic [32:0]        re_sc, im_sc;

  assign acc      = sink_valid & ready_q;
  assign out_fire = out_valid_q & source_ready;
  assign last     = (cnt_q == LAST);
  assign s_new    = calc_shift(sink_exp);
  assign s_use    = sink_sop ? s_new : s_q;
  assign re_sc    = scale_fn(sink_real, s_use);
  assign im_sc    = scale_fn(sink_imag, s_use);

  // Frame tracking: shift latch, beat counter, error pulse and sticky saturation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    s_d         = s_q;
    sat_d       = sat_q;
    frame_err_d = 1'b0;
    beat_v      = 1'b0;
    beat.re     = re_sc[31:0];
    beat.im     = im_sc[31:0];
    beat.err    = sink_error;
    beat.sop    = 1'b0;
    beat.eop    = 1'b0;
    if (acc && sink_sop) begin
      // A sop always (re)starts a frame; one arriving mid-frame is a violation.
      frame_err_d = (state_q == FRAME) | sink_eop;
      state_d     = FRAME;
      cnt_d       = CW'(1);
      s_d         = s_new;
      sat_d       = re_sc[32] | im_sc[32];
      beat_v      = 1'b1;
      beat.sop    = 1'b1;
    end else if (acc) begin
      case (state_q)
        FRAME: begin
          beat_v      = 1'b1;
          beat.eop    = last;
          frame_err_d = sink_eop ^ last;
          sat_d       = sat_q | re_sc[32] | im_sc[32];
          if (last) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        IDLE:    frame_err_d = 1'b1;
        default: state_d = IDLE;
      endcase
    end else begin
      beat_v = 1'b0;
    end
  end

  // Output register plus one-entry skid buffer; the skid only fills when output stalls.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    skid_full_d = skid_full_q;
    skid_d      = skid_q;
    if (skid_full_q) begin
      if (out_fire) begin
        out_d       = skid_q;
        skid_full_d = 1'b0;
      end else begin
        out_d = out_q;
      end
    end else if (out_valid_q && !source_ready) begin
      if (beat_v) begin
        skid_d      = beat;
        skid_full_d = 1'b1;
      end else begin
        skid_full_d = 1'b0;
      end
    end else begin
      out_valid_d = beat_v;
      out_d       = beat_v ? beat : out_q;
    end
    ready_d = ~skid_full_d;
  end

  // State registers; reset empties the pipeline and clears all outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      s_q         <= 6'sd0;
      ready_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      skid_full_q <= 1'b0;
      skid_q      <= '0;
      frame_err_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      skid_full_q <= skid_full_d;
      skid_q      <= skid_d;
      frame_err_q <= frame_err_d;
      sat_q       <= sat_d;
    end
  end

  assign sink_ready   = ready_q;
  assign source_valid = out_valid_q;
  assign source_real  = out_q.re;
  assign source_imag  = out_q.im;
  assign source_error = out_q.err;
  assign source_sop   = out_q.sop;
  assign source_eop   = out_q.eop;
  assign frame_err    = frame_err_q;
  assign sat_flag     = sat_q;

endmodule

// File: tb/tb_fft_bfp_scale.sv
// Scoreboard bench for fft_bfp_scale: stimulus pushes expected beats from an arithmetic
// reference model; an independent monitor pops and compares on every source transfer.
module tb_fft_bfp_scale;
  localparam int FL  = 8;
  localparam int ADJ = 0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sink_valid, sink_ready, sink_sop, sink_eop;
  logic [1:0]  sink_error;
  logic [31:0] sink_real, sink_imag;
  logic [5:0]  sink_exp;
  logic        source_valid, source_ready, source_sop, source_eop;
  logic [1:0]  source_error;
  logic [31:0] source_real, source_imag;
  logic        frame_err, sat_flag;

  fft_bfp_scale #(.FRAME_LEN(FL), .SHIFT_ADJ(ADJ)) dut (
    .clk(clk), .reset_n(reset_n),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_error(sink_error),
    .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_real(sink_real), .sink_imag(sink_imag),
    .sink_exp(sink_exp),
    .source_valid(source_valid), .source_ready(source_ready), .source_error(source_error),
    .source_sop(source_sop), .source_eop(source_eop), .source_real(source_real),
    .source_imag(source_imag), .frame_err(frame_err), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
    logic [1:0]  err;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    rmode  = 0;
  bit    chk_lat = 0;
  bit    armed;

  // reference model state
  bit m_in;
  int m_idx;
  int m_s;
  bit m_sat;

  function automatic void scale_ref(input logic [31:0] x, input int s,
                                    output logic [31:0] y, output bit sat);
    longint v, d, q;
    v   = longint'($signed(x));
    sat = 1'b0;
    if (s >= 0) begin
      v = v * (longint'(1) << s);
      if (v > 64'sd2147483647) begin y = 32'h7FFF_FFFF; sat = 1'b1; end
      else if (v < -64'sd2147483648) begin y = 32'h8000_0000; sat = 1'b1; end
      else y = v[31:0];
    end else begin
      d = longint'(1) << (-s);
      q = v / d;
      if (v < 0 && q * d != v) q = q - 1;
      y = q[31:0];
    end
  endfunction

  task automatic model_accept(input bit sop, input bit eop, input logic [5:0] ex,
                              input logic [31:0] re, input logic [31:0] im,
                              input logic [1:0] er, output bit ferr);
    beat_t b;
    bit    out, sr, si;
    b = '0; out = 1'b0; ferr = 1'b0;
    if (sop) begin
      ferr  = m_in || eop;
      m_s   = ADJ - int'($signed(ex));
      if (m_s > 31) m_s = 31;
      if (m_s < -31) m_s = -31;
      m_in  = 1'b1; m_idx = 1; m_sat = 1'b0;
      b.sop = 1'b1; out = 1'b1;
    end else if (!m_in) begin
      ferr = 1'b1;
    end else begin
      b.eop = (m_idx == FL - 1);
      ferr  = (eop != b.eop);
      out   = 1'b1;
      if (b.eop) begin m_in = 1'b0; m_idx = 0; end
      else m_idx++;
    end
    if (out) begin
      scale_ref(re, m_s, b.re, sr);
      scale_ref(im, m_s, b.im, si);
      m_sat = m_sat | sr | si;
      b.err = er;
      sb.push_back(b);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic send_beat(input bit sop, input bit eop, input logic [5:0] ex,
                           input logic [31:0] re, input logic [31:0] im, input logic [1:0] er);
    bit ok, ferr;
    int n;
    sink_valid = 1'b1; sink_sop = sop; sink_eop = eop; sink_exp = ex;
    sink_real = re; sink_imag = im; sink_error = er;
    ok = 1'b0; n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (sink_ready) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL sink_timeout: sink_ready stayed %b, expected 1", sink_ready);
      sink_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      sink_valid = 1'b0;
      model_accept(sop, eop, ex, re, im, er, ferr);
      check32("frame_err", {31'd0, frame_err}, {31'd0, ferr});
      check32("sat_flag", {31'd0, sat_flag}, {31'd0, m_sat});
      if (chk_lat) check32("latency_valid", {31'd0, source_valid}, 32'd1);
    end
  endtask

  // downstream ready pattern, updated just after each rising edge
  always @(posedge clk) begin
    #2;
    case (rmode)
      0:       source_ready = 1'b1;
      1:       source_ready = ~source_ready;
      2:       source_ready = 1'($urandom_range(0, 1));
      default: source_ready = 1'b0;
    endcase
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) armed <= 1'b0;
    else armed <= 1'b1;
  end

  // monitor: occupancy vs. sink_ready, stall stability, and scoreboard compare
  beat_t cur, hold, e;
  bit    hold_v = 1'b0;
  always @(negedge clk) begin
    cur = {source_real, source_imag, source_error, source_sop, source_eop};
    if (!reset_n) begin
      hold_v = 1'b0;
    end else begin
      if (armed) begin
        checks++;
        if (sink_ready !== (sb.size() < 2)) begin
          errors++;
          $display("FAIL ready_occupancy: sink_ready %b with %0d beats in flight", sink_ready, sb.size());
        end
      end
      if (hold_v) begin
        checks++;
        if (!source_valid || cur !== hold) begin
          errors++;
          $display("FAIL stall_stable: got v=%b %h expected v=1 %h", source_valid, cur, hold);
        end
      end
      hold_v = source_valid && !source_ready;
      hold   = cur;
      if (source_valid && source_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h expected none", cur);
        end else begin
          e = sb.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL beat: got %h expected %h", cur, e);
          end
        end
      end
    end
  end

  initial begin
    bit   sop, eop;
    int   rs, n;
    logic [5:0]  ex;
    logic [31:0] re, im;
    reset_n = 1'b0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    sink_error = 2'd0; sink_real = 32'd0; sink_imag = 32'd0; sink_exp = 6'd0;
    source_ready = 1'b1;
    m_in = 1'b0; m_idx = 0; m_s = 0; m_sat = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check32("reset_outputs", {30'd0, source_valid, sink_ready},
            32'd0);
    check32("reset_data", source_real | source_imag | {28'd0, source_error, source_sop, source_eop}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check32("ready_after_reset", {31'd0, sink_ready}, 32'd1);

    // basic frame, exp=-3 -> left shift by 3, one-cycle latency
    chk_lat = 1'b1;
    for (int i = 0; i < FL; i++) begin
      send_beat(i == 0, i == FL - 1, 6'h3D, 32'h10, 32'hFFFF_FFF0, 2'(i));
      check32("direct_real_x8", source_real, 32'h80);
      check32("direct_imag_x8", source_imag, 32'hFFFF_FF80);
    end
    // floor right shift, then saturation
    send_beat(1'b1, 1'b0, 6'd2, 32'hFFFF_FFFB, 32'd7, 2'd1);
    check32("direct_floor", source_real, 32'hFFFF_FFFE);
    for (int i = 1; i < FL; i++) send_beat(1'b0, i == FL - 1, 6'd2, 32'hFFFF_FFFB, 32'(i), 2'd0);
    send_beat(1'b1, 1'b0, 6'h3C, 32'h1000_0000, 32'd1, 2'd2);
    check32("direct_sat", source_real, 32'h7FFF_FFFF);
    check32("direct_sat_flag", {31'd0, sat_flag}, 32'd1);
    for (int i = 1; i < FL; i++) send_beat(1'b0, i == FL - 1, 6'h3C, 32'(i), 32'hF000_0000, 2'd3);
    chk_lat = 1'b0;

    // ready toggling
    rmode = 1;
    for (int i = 0; i < FL; i++) send_beat(i == 0, i == FL - 1, 6'($urandom), $urandom, $urandom, 2'($urandom));
    // stray beat in IDLE, restart at cnt=4
    rmode = 0;
    send_beat(1'b0, 1'b0, 6'd0, 32'd5, 32'd5, 2'd0);
    for (int i = 0; i < 4; i++) send_beat(i == 0, 1'b0, 6'h3E, 32'(i + 1), 32'd0, 2'd0);
    for (int i = 0; i < FL; i++) send_beat(i == 0, i == FL - 1, 6'h3F, 32'(100 + i), 32'd3, 2'd1);
    // early eop on beat 6
    for (int i = 0; i < FL; i++) send_beat(i == 0, i == 5 || i == FL - 1, 6'd1, 32'(i * 12), 32'd9, 2'd0);

    // reset with cnt=5 and skid full
    for (int i = 0; i < 4; i++) send_beat(i == 0, 1'b0, 6'd0, 32'(i), 32'(i), 2'd0);
    rmode = 3;
    send_beat(1'b0, 1'b0, 6'd0, 32'd4, 32'd4, 2'd0);
    @(negedge clk); #1;
    check32("skid_full_ready", {31'd0, sink_ready}, 32'd0);
    reset_n = 1'b0;
    #1;
    check32("midreset_ctrl", {26'd0, source_valid, sink_ready, source_sop, source_eop, frame_err, sat_flag}, 32'd0);
    check32("midreset_data", source_real | source_imag | {30'd0, source_error}, 32'd0);
    sb.delete();
    m_in = 1'b0; m_idx = 0; m_s = 0; m_sat = 1'b0;
    rmode = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < FL; i++) send_beat(i == 0, i == FL - 1, 6'h3D, 32'(i - 4), 32'd1, 2'd2);

    // randomized frames with random ready and occasional framing faults
    rmode = 2;
    for (int f = 0; f < 25; f++) begin
      ex = 6'($urandom);
      if ($urandom_range(0, 7) == 0) send_beat(1'b0, 1'b0, ex, $urandom, $urandom, 2'd0);
      rs = ($urandom_range(0, 5) == 0) ? $urandom_range(1, FL - 1) : -1;
      for (int i = 0; i < FL; i++) begin
        re  = $urandom >> $urandom_range(0, 31);
        im  = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) re = -re;
        sop = (i == 0) || (i == rs);
        eop = (i == FL - 1) ^ ($urandom_range(0, 15) == 0);
        send_beat(sop, eop, sop ? ex : 6'($urandom), re, im, 2'($urandom));
      end
    end

    rmode = 0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check32("drain_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
